// File: rtl/traffic_pkg.sv
// Shared codes, FSM state type and sensor-to-density mapping for the junction
// phase scheduler.
package traffic_pkg;

    localparam logic [2:0] RD_EMPTY = 3'b000;
    localparam logic [2:0] RD_LESS  = 3'b001;
    localparam logic [2:0] RD_MORE  = 3'b011;
    localparam logic [2:0] RD_FULL  = 3'b111;

    localparam logic [1:0] LT_RED    = 2'b00;
    localparam logic [1:0] LT_GREEN  = 2'b01;
    localparam logic [1:0] LT_YELLOW = 2'b10;

    typedef enum logic [1:0] {
        ST_ALL_RED = 2'b00,
        ST_GREEN   = 2'b01,
        ST_YELLOW  = 2'b10
    } state_e;

    // Highest set sensor bit decides the level, so non-canonical codes still map.
    function automatic logic [1:0] density_level(input logic [2:0] sensor);
        logic [1:0] lvl;
        if (sensor[2]) begin
            lvl = 2'd3;
        end else if (sensor[1]) begin
            lvl = 2'd2;
        end else if (sensor[0]) begin
            lvl = 2'd1;
        end else begin
            lvl = 2'd0;
        end
        return lvl;
    endfunction

endpackage

// File: rtl/phase_selector.sv
// Combinational winner pick: starvation filter, highest density, round-robin
// tie-break starting after the last served road.
module phase_selector
    import traffic_pkg::*;
#(
    parameter int unsigned MAX_SKIP = 3
) (
    input  logic [3:0][1:0] level_i,
    input  logic [3:0][3:0] skip_i,
    input  logic [1:0]      last_served_i,
    output logic [1:0]      winner_o,
    output logic            valid_o
);

    localparam logic [3:0] SKIP_MAX = 4'(MAX_SKIP);

    logic       starved_s;
    logic       eligible_s;
    logic [1:0] idx_s;
    logic [1:0] best_lvl_s;

    // Scan in round-robin order; strict '>' keeps the earliest road on a tie.
    always_comb begin
        starved_s  = 1'b0;
        eligible_s = 1'b0;
        idx_s      = 2'd0;
        best_lvl_s = 2'd0;
        winner_o   = 2'd0;
        valid_o    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            starved_s = starved_s | ((level_i[i] != 2'd0) && (skip_i[i] == SKIP_MAX));
        end
        for (int k = 1; k <= 4; k++) begin
            idx_s      = last_served_i + 2'(k);
            eligible_s = (level_i[idx_s] != 2'd0) &&
                         (!starved_s || (skip_i[idx_s] == SKIP_MAX));
            if (eligible_s && (level_i[idx_s] > best_lvl_s)) begin
                best_lvl_s = level_i[idx_s];
                winner_o   = idx_s;
                valid_o    = 1'b1;
            end else begin
                best_lvl_s = best_lvl_s;
            end
        end
    end

endmodule

// File: rtl/density_phase_scheduler.sv
// Junction phase FSM: picks a road by congestion, then walks it through
// green (with gap-out), yellow and all-red clearance.
module density_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_LESS  = 3,
    parameter int unsigned GREEN_MORE  = 5,
    parameter int unsigned GREEN_FULL  = 8,
    parameter int unsigned YELLOW_TIME = 2,
    parameter int unsigned ALLRED_TIME = 1,
    parameter int unsigned MIN_GREEN   = 2,
    parameter int unsigned MAX_SKIP    = 3
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [2:0] S1,
    input  logic [2:0] S2,
    input  logic [2:0] S3,
    input  logic [2:0] S4,
    output logic [1:0] T1,
    output logic [1:0] T2,
    output logic [1:0] T3,
    output logic [1:0] T4,
    output logic [3:0] T,
    output logic [3:0] delay_counter
);

    localparam logic [3:0] G_LESS   = 4'(GREEN_LESS);
    localparam logic [3:0] G_MORE   = 4'(GREEN_MORE);
    localparam logic [3:0] G_FULL   = 4'(GREEN_FULL);
    localparam logic [3:0] YEL_M1   = 4'(YELLOW_TIME - 1);
    localparam logic [3:0] AR_M1    = 4'(ALLRED_TIME - 1);
    localparam logic [3:0] MIN_G    = 4'(MIN_GREEN);
    localparam logic [3:0] SKIP_MAX = 4'(MAX_SKIP);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [3:0]      dur_q, dur_d;
    logic [1:0]      road_q, road_d;
    logic [1:0]      last_q, last_d;
    logic [3:0][3:0] skip_q, skip_d;
    logic [3:0][1:0] lights_q, lights_d;
    logic [3:0]      grant_q, grant_d;

    logic [3:0][2:0] sensor_s;
    logic [3:0][1:0] level_s;
    logic [1:0]      sel_winner_s;
    logic            sel_valid_s;
    logic [3:0]      elapsed_s;
    logic            gap_out_s;

    assign sensor_s = {S4, S3, S2, S1};

    // Per-road density levels feeding the selector.
    always_comb begin
        level_s = '0;
        for (int i = 0; i < 4; i++) begin
            level_s[i] = density_level(sensor_s[i]);
        end
    end

    phase_selector #(
        .MAX_SKIP(MAX_SKIP)
    ) u_selector (
        .level_i      (level_s),
        .skip_i       (skip_q),
        .last_served_i(last_q),
        .winner_o     (sel_winner_s),
        .valid_o      (sel_valid_s)
    );

    // Green cycles shown so far, counting the current one.
    assign elapsed_s = dur_q - cnt_q;
    assign gap_out_s = (sensor_s[road_q] == RD_EMPTY) && (elapsed_s >= MIN_G);

    // Phase sequencing, selection bookkeeping and skip-count update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dur_d   = dur_q;
        road_d  = road_q;
        last_d  = last_q;
        skip_d  = skip_q;
        case (state_q)
            ST_ALL_RED: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (sel_valid_s) begin
                    state_d = ST_GREEN;
                    road_d  = sel_winner_s;
                    last_d  = sel_winner_s;
                    case (level_s[sel_winner_s])
                        2'd3:    dur_d = G_FULL;
                        2'd2:    dur_d = G_MORE;
                        default: dur_d = G_LESS;
                    endcase
                    cnt_d = dur_d - 4'd1;
                    for (int i = 0; i < 4; i++) begin
                        if (2'(i) == sel_winner_s) begin
                            skip_d[i] = 4'd0;
                        end else if ((level_s[i] != 2'd0) && (skip_q[i] != SKIP_MAX)) begin
                            skip_d[i] = skip_q[i] + 4'd1;
                        end else begin
                            skip_d[i] = skip_q[i];
                        end
                    end
                end else begin
                    cnt_d = 4'd0;
                end
            end
            ST_GREEN: begin
                if ((cnt_q == 4'd0) || gap_out_s) begin
                    state_d = ST_YELLOW;
                    cnt_d   = YEL_M1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_YELLOW: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_ALL_RED;
                    cnt_d   = AR_M1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_ALL_RED;
                cnt_d   = AR_M1;
            end
        endcase
    end

    // Light and grant values for the next cycle, so the outputs leave flops.
    always_comb begin
        lights_d = {LT_RED, LT_RED, LT_RED, LT_RED};
        grant_d  = 4'b0000;
        case (state_d)
            ST_GREEN: begin
                lights_d[road_d] = LT_GREEN;
                grant_d[road_d]  = 1'b1;
            end
            ST_YELLOW: begin
                lights_d[road_d] = LT_YELLOW;
                grant_d[road_d]  = 1'b1;
            end
            default: begin
                grant_d = 4'b0000;
            end
        endcase
    end

    // State and output registers; clear forces all-red with no yellow.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q  <= ST_ALL_RED;
            cnt_q    <= AR_M1;
            dur_q    <= 4'd0;
            road_q   <= 2'd0;
            last_q   <= 2'd3;
            skip_q   <= '0;
            lights_q <= {LT_RED, LT_RED, LT_RED, LT_RED};
            grant_q  <= 4'b0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dur_q    <= dur_d;
            road_q   <= road_d;
            last_q   <= last_d;
            skip_q   <= skip_d;
            lights_q <= lights_d;
            grant_q  <= grant_d;
        end
    end

    assign T1            = lights_q[0];
    assign T2            = lights_q[1];
    assign T3            = lights_q[2];
    assign T4            = lights_q[3];
    assign T             = grant_q;
    assign delay_counter = cnt_q;

endmodule
